// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - LFSR stream checker: fills history, searches for lock, tracks errors while locked
//
// Ports:
//   clock       rising-edge clock for all state
//   reset       synchronous active-high reset
//   in_valid    in_bit carries a received stream bit this cycle
//   in_bit      received serial bit, in generation order
//   clear_errs  synchronous clear of err_count
//   locked      registered, high while the checker is locked
//   err_pulse   registered one-cycle pulse per locked mismatch
//   err_count   registered saturating count of locked mismatches
module lfsr_checker #(
    parameter int NUM_BITS   = 4,
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_BITS   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_bit,
    input  logic                clear_errs,
    output logic                locked,
    output logic                err_pulse,
    output logic [ERR_BITS-1:0] err_count
);

    localparam int FW = $clog2(NUM_BITS + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

    state_t              state, state_next;
    logic [NUM_BITS-1:0] hist, hist_next;
    logic [FW-1:0]       fill_cnt, fill_next;
    logic [MW-1:0]       match_cnt, match_next;
    logic [LW-1:0]       miss_cnt, miss_next;

    // History widened to 5 bits so the 5-bit tap positions stay in range
    // for every legal NUM_BITS.
    logic [4:0] hist_x;
    logic       predict;
    logic       wrong;
    logic       miss_now;
    logic       count_err;

    always_comb begin
        hist_x  = 5'(hist);
        predict = (NUM_BITS == 5) ? (hist_x[1] ^ hist_x[4])
                                  : (hist_x[0] ^ hist_x[NUM_BITS-1]);
        wrong   = in_bit != predict;
        // An all-zero history predicts zero forever, so it must never
        // count toward lock.
        miss_now  = in_valid && (wrong || (state == SEARCH && hist == '0));
        count_err = in_valid && (state == LOCKED) && wrong;
    end

    always_comb begin
        state_next = state;
        hist_next  = hist;
        fill_next  = fill_cnt;
        match_next = match_cnt;
        miss_next  = miss_cnt;
        if (in_valid) begin
            case (state)
                FILL: begin
                    hist_next = {hist[NUM_BITS-2:0], in_bit};
                    if (fill_cnt == FW'(NUM_BITS - 1)) begin
                        state_next = SEARCH;
                        fill_next  = '0;
                    end else begin
                        fill_next = fill_cnt + 1'b1;
                    end
                end
                SEARCH: begin
                    hist_next = {hist[NUM_BITS-2:0], in_bit};
                    if (miss_now) begin
                        match_next = '0;
                    end else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                        state_next = LOCKED;
                        match_next = '0;
                    end else begin
                        match_next = match_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    // Free-run on our own prediction so a single received
                    // bit error cannot corrupt the following predictions.
                    hist_next = {hist[NUM_BITS-2:0], predict};
                    if (miss_now) begin
                        if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
                            state_next = FILL;
                            fill_next  = '0;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_next = '0;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            hist      <= hist_next;
            fill_cnt  <= fill_next;
            match_cnt <= match_next;
            miss_cnt  <= miss_next;
            locked    <= (state_next == LOCKED);
            err_pulse <= count_err;
            if (clear_errs) begin
                err_count <= count_err ? ERR_BITS'(1) : '0;
            end else if (count_err && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clear_errs = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked2, err_pulse2;
    logic [1:0]  err_count2;

    int errors = 0;
    int checks = 0;
    int pos = 0;
    bit seq [15] = '{1, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1};

    always #5 clock = ~clock;

    lfsr_checker dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .clear_errs(clear_errs), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    lfsr_checker #(.ERR_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .clear_errs(clear_errs), .locked(locked2), .err_pulse(err_pulse2),
        .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic clr);
        in_valid   = v;
        in_bit     = b;
        clear_errs = clr;
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
        clear_errs = 1'b0;
    endtask

    // Send the next stream bit, optionally inverted.
    task automatic send(input logic inv, input logic clr);
        logic b;
        b   = seq[pos];
        pos = (pos + 1) % 15;
        step(1'b1, b ^ inv, clr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        int ever;
        int nvalid;

        // Reset state
        do_reset();
        chk("reset_locked", locked, 0);
        chk("reset_pulse", err_pulse, 0);
        chk("reset_count", err_count, 0);

        // Lock after 12 valid bits, no errors over 100 bits
        pos = 0;
        for (int i = 0; i < 11; i++) send(0, 0);
        chk("lock_after11", locked, 0);
        send(0, 0);
        chk("lock_after12", locked, 1);
        pulses = 0;
        for (int i = 12; i < 100; i++) begin
            send(0, 0);
            pulses += int'(err_pulse);
        end
        chk("clean_pulses", pulses, 0);
        chk("clean_count", err_count, 0);
        chk("clean_locked", locked, 1);

        // Single bit error
        send(1, 0);
        chk("single_pulse", err_pulse, 1);
        chk("single_count", err_count, 1);
        chk("single_locked", locked, 1);
        send(0, 0);
        chk("single_pulse_end", err_pulse, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            send(0, 0);
            pulses += int'(err_pulse);
        end
        chk("single_after_pulses", pulses, 0);
        chk("single_after_count", err_count, 1);

        // clear_errs alone
        send(0, 1);
        chk("clear_alone", err_count, 0);
        chk("clear_keeps_lock", locked, 1);

        // Loss of lock after 4 consecutive errors
        for (int i = 0; i < 3; i++) begin
            send(1, 0);
            chk("loss_pre_pulse", err_pulse, 1);
            chk("loss_pre_locked", locked, 1);
        end
        send(1, 0);
        chk("loss_count", err_count, 4);
        chk("loss_locked", locked, 0);
        chk("loss_pulse", err_pulse, 1);
        for (int i = 0; i < 11; i++) send(0, 0);
        chk("relock_after11", locked, 0);
        chk("relock_pulse", err_pulse, 0);
        send(0, 0);
        chk("relock_after12", locked, 1);
        chk("relock_count", err_count, 4);

        // All-zero stream never locks
        do_reset();
        ever = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b0);
            ever += int'(locked);
        end
        chk("zero_never_locked", ever, 0);
        chk("zero_count", err_count, 0);

        // Saturation with ERR_BITS=2
        do_reset();
        for (int i = 0; i < 12; i++) send(0, 0);
        chk("sat_locked", locked2, 1);
        for (int e = 0; e < 3; e++) begin
            send(1, 0);
            for (int i = 0; i < 3; i++) send(0, 0);
        end
        chk("sat_count3", err_count2, 3);
        for (int e = 0; e < 2; e++) begin
            send(1, 0);
            chk("sat_pulse", err_pulse2, 1);
            for (int i = 0; i < 3; i++) send(0, 0);
        end
        chk("sat_held", err_count2, 3);
        chk("sat_still_locked", locked2, 1);
        send(1, 1);
        chk("clear_with_err", err_count2, 1);
        chk("clear_with_err_pulse", err_pulse2, 1);

        // Random idle cycles, reset while locked
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 200 && nvalid < 14; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                step(1'b0, 1'b1, 1'b0);
            end else begin
                send(0, 0);
                nvalid++;
            end
        end
        chk("idle_locked", locked, 1);
        send(1, 0);
        chk("idle_err_pulse", err_pulse, 1);
        reset = 1'b1;
        send(0, 0);
        reset = 1'b0;
        chk("midreset_locked", locked, 0);
        chk("midreset_pulse", err_pulse, 0);
        chk("midreset_count", err_count, 0);
        nvalid = 0;
        for (int i = 0; i < 300 && nvalid < 11; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, 1'b0, 1'b0);
                chk("idle_hold", locked, 0);
            end else begin
                send(0, 0);
                nvalid++;
            end
        end
        chk("midreset_valid11", nvalid, 11);
        chk("midreset_after11", locked, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("midreset_idle", locked, 0);
        send(0, 0);
        chk("midreset_after12", locked, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter NUM_BITS, default 4, the checked LFSR length; legal values 2..5.
REQ-002 SHALL have parameter LOCK_COUNT, default 8, the number of consecutive correct predictions required to lock.
REQ-003 SHALL have parameter LOSS_COUNT, default 4, the number of consecutive mispredictions in LOCKED that declare loss of lock.
REQ-004 SHALL have parameter ERR_BITS, default 16, the error counter width.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_bit is a received stream bit this cycle.
REQ-008 in_bit  input  1  received serial bit, in generation order.
REQ-009 clear_errs  input  1  synchronous clear of err_count.
REQ-010 locked  output  1  registered; high while FSM is LOCKED.
REQ-011 err_pulse  output  1  registered; one-cycle pulse per mismatch detected in LOCKED.
REQ-012 err_count  output  ERR_BITS  registered, saturating count of LOCKED mismatches.

Function
REQ-013 Stream recurrence SHALL be b[n] = b[n-1] XOR b[n-NUM_BITS] for NUM_BITS 2..4, and b[n] = b[n-2] XOR b[n-5] for NUM_BITS 5, matching the team's LFSR generator's shifted-in bit.
REQ-014 History register hist[NUM_BITS-1:0] SHALL hold the last NUM_BITS bits, hist[0] newest; it updates only on in_valid cycles.
REQ-015 Prediction SHALL be hist[0]^hist[NUM_BITS-1] (NUM_BITS 2..4) or hist[1]^hist[4] (NUM_BITS 5); mismatch = in_valid AND (in_bit != prediction).
REQ-016 FSM states SHALL be FILL, SEARCH, LOCKED; cycles with in_valid low SHALL change no state, counter or history.
REQ-017 FILL: each valid bit shifts in_bit into hist; after the NUM_BITS-th valid bit, next state SEARCH; no predictions made.
REQ-018 SEARCH: each valid bit shifts in_bit into hist; correct prediction increments match counter, mismatch clears it to 0; the LOCK_COUNT-th consecutive correct bit moves to LOCKED.
REQ-019 SEARCH: a prediction made from hist == all zeros SHALL count as a mismatch (no lock on an all-zero stream).
REQ-020 LOCKED: hist SHALL shift in the predicted bit, not in_bit (free-running; one bit error yields exactly one mismatch).
REQ-021 LOCKED: mismatch increments miss counter and err_count; correct prediction clears miss counter; the LOSS_COUNT-th consecutive mismatch moves to FILL with fill, match and miss counters cleared.
REQ-022 locked SHALL rise the cycle after the locking bit is accepted and fall the cycle after the loss-declaring bit is accepted.
REQ-023 err_pulse SHALL assert for exactly one cycle, the cycle after each LOCKED mismatch, including the loss-declaring one.
REQ-024 err_count SHALL saturate at all ones and not wrap.
REQ-025 clear_errs with a simultaneous counted mismatch SHALL leave err_count = 1; clear_errs alone SHALL leave 0; clear_errs SHALL not affect FSM or err_pulse.
REQ-026 Mismatches outside LOCKED SHALL not assert err_pulse nor change err_count.

Reset
REQ-027 reset SHALL force state FILL, hist = 0, all internal counters = 0, locked = 0, err_pulse = 0, err_count = 0 on the next edge, overriding every other input.
REQ-028 reset asserted mid-stream, including while LOCKED, SHALL discard all history; relock requires NUM_BITS + LOCK_COUNT fresh valid bits.

Verification
REQ-029 NUM_BITS=4, reset, stream 1,1,1,0,1,0,1,1,0,0,1,0,0,0,1 (period 15) one bit per cycle -> locked rises the cycle after valid bit 12; err_count stays 0 over 100 bits.
REQ-030 Locked as above, invert one stream bit -> exactly one err_pulse, err_count = 1, locked stays high.
REQ-031 Locked, drive 4 consecutive inverted bits -> err_count = 4, locked low the cycle after 4th bit; resume correct stream -> relock after 4 + 8 further valid bits.
REQ-032 Constant in_bit = 0 for 50 valid bits after reset -> locked never asserts, err_count = 0.
REQ-033 ERR_BITS=2, locked, 3 isolated bit errors then 2 more -> err_count 3 and held; clear_errs coincident with an error -> err_count = 1.
REQ-034 Correct stream with in_valid toggling randomly, reset pulsed while LOCKED -> all outputs 0 next cycle; lock reached after 12 further valid bits regardless of idle cycles.
